// File: rtl/axis_packet_tx.sv
// axis_packet_tx: FIFO-buffered AXI4-Stream packet transmitter.
// Frames each packet with TDEST from the first word, TUSER[0] on the first beat and TLAST on the last.
module axis_packet_tx #(
  parameter int DEPTH   = 16,
  parameter int MAX_LEN = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [31:0]              wr_data,
  input  logic                     wr_last,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [31:0]              m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [7:0]               m_axis_tdest,
  output logic [3:0]               m_axis_tuser,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     pkt_done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BODY = 1'b1;
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level;
  logic [0:0]    state;
  logic [7:0]    dest;
  logic [15:0]   cnt, cnt_nxt;
  logic [32:0]   head;
  logic          en, push, pop, first, last_beat;
  // en keeps wr_ready low while in reset and rises on the first edge after release
  assign wr_ready   = en && (level != (AW+1)'(DEPTH));
  assign fifo_level = level;
  assign push       = wr_valid && wr_ready;
  assign pop        = (level != '0) && (!m_axis_tvalid || m_axis_tready);
  assign head       = mem[rptr];
  assign first      = state == IDLE;
  assign cnt_nxt    = first ? 16'd1 : cnt + 16'd1;
  assign last_beat  = head[32] || (cnt_nxt == 16'(MAX_LEN));
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {wr_last, wr_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      en            <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      level         <= '0;
      state         <= IDLE;
      dest          <= '0;
      cnt           <= '0;
      pkt_done      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdest  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      en       <= 1'b1;
      wptr     <= wptr + AW'(push);
      rptr     <= rptr + AW'(pop);
      level    <= level + (AW+1)'(push) - (AW+1)'(pop);
      pkt_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
      if (pop) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= head[31:0];
        m_axis_tlast  <= last_beat;
        m_axis_tuser  <= {3'b0, first};
        m_axis_tdest  <= first ? head[31:24] : dest;
        dest          <= first ? head[31:24] : dest;
        cnt           <= last_beat ? '0 : cnt_nxt;
        state         <= last_beat ? IDLE : BODY;
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_axis_packet_tx.sv
// tb_axis_packet_tx: randomized scenario bench for axis_packet_tx against a packet-framing reference model.
module tb_axis_packet_tx;
  localparam int DEPTH   = 16;
  localparam int MAX_LEN = 4;
  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [3:0]  u;
    logic [7:0]  t;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_valid = 1'b0, wr_last = 1'b0, m_axis_tready = 1'b0;
  logic [31:0] wr_data = '0;
  logic wr_ready, m_axis_tvalid, m_axis_tlast, pkt_done;
  logic [31:0] m_axis_tdata;
  logic [7:0] m_axis_tdest;
  logic [3:0] m_axis_tuser;
  logic [$clog2(DEPTH):0] fifo_level;
  int errors = 0, checks = 0;
  beat_t exp[$], got[$];
  int gcyc[$];
  int cyc = 0, stab_bad = 0, pd_bad = 0, pd_cnt = 0;
  logic mpkt = 1'b0;
  logic [7:0] mdest = '0;
  int mbeats = 0, mpkts = 0;
  int tr_mode = 0, pi = 0;
  int pat[4] = '{1, 0, 0, 1};
  beat_t cur, pv_beat;
  logic pv_stall = 1'b0, pv_hl = 1'b0;

  axis_packet_tx #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
    .m_axis_tuser(m_axis_tuser), .fifo_level(fifo_level), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;
  assign cur = '{m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tdest};

  // Observes the stream mid-cycle; handshakes seen here complete at the next rising edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pv_stall = 1'b0;
      pv_hl    = 1'b0;
    end else begin
      if (pv_stall && cur != pv_beat) stab_bad++;
      if (pkt_done !== pv_hl) pd_bad++;
      if (pkt_done) pd_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        got.push_back(cur);
        gcyc.push_back(cyc);
      end
      pv_stall = m_axis_tvalid && !m_axis_tready;
      pv_beat  = cur;
      pv_hl    = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    end
  end

  always @(posedge clk) begin
    #1;
    if (tr_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
    else if (tr_mode == 2) begin
      m_axis_tready = 1'(pat[pi]);
      pi = (pi + 1) % 4;
    end
  end

  // Framing follows from the word order alone: first word opens a packet, wr_last or MAX_LEN beats close it
  function automatic void model_push(input logic [31:0] d, input logic l);
    logic f, lst;
    f = !mpkt;
    if (f) begin
      mdest  = d[31:24];
      mbeats = 0;
    end
    mbeats++;
    lst = l || (mbeats == MAX_LEN);
    exp.push_back('{d, lst, {3'b0, f}, mdest});
    if (lst) mpkts++;
    mpkt = !lst;
  endfunction

  task automatic wr(input logic [31:0] d, input logic l);
    int n = 0;
    wr_data = d; wr_last = l; wr_valid = 1'b1;
    while (!wr_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!wr_ready) begin
      errors++;
      $display("FAIL wr_timeout: wr_ready=%b required 1", wr_ready);
    end else model_push(d, l);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic start();
    exp.delete(); got.delete(); gcyc.delete();
    stab_bad = 0; pd_bad = 0; pd_cnt = 0; mpkts = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (got.size() < exp.size() && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest, m_axis_tuser, fifo_level, pkt_done, wr_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: tvalid=%b tdata=%h tlast=%b tdest=%h tuser=%h level=%0d pkt_done=%b wr_ready=%b required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest, m_axis_tuser, fifo_level, pkt_done, wr_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: wr_ready=%b required 1", wr_ready);
    end
  endtask

  task automatic test_three_word();
    start();
    tr_mode = 0; m_axis_tready = 1'b1;
    wr(32'hA500_0001, 1'b0); wr(32'h0000_0002, 1'b0); wr(32'h0000_0003, 1'b1);
    drain();
    checks++;
    if (got.size() !== 3) begin errors++; $display("FAIL three_count: got %0d beats required 3", got.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL three_beat%0d: got %h required %h", i, (i < got.size()) ? got[i] : '0, exp[i]);
      end
    end
    checks++;
    if (got.size() == 3 && gcyc[2] - gcyc[0] !== 2) begin
      errors++; $display("FAIL three_consecutive: span %0d required 2", gcyc[2] - gcyc[0]);
    end
    checks++;
    if (pd_cnt !== 1 || pd_bad !== 0) begin
      errors++; $display("FAIL three_pkt_done: pulses=%0d misaligned=%0d required 1/0", pd_cnt, pd_bad);
    end
  endtask

  task automatic test_backpressure();
    start();
    tr_mode = 2; pi = 0;
    wr(32'hA500_0001, 1'b0); wr(32'h0000_0002, 1'b0); wr(32'h0000_0003, 1'b1);
    drain();
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h required %h", i, (i < got.size()) ? got[i] : '0, exp[i]);
      end
    end
    checks++;
    if (got.size() !== exp.size() || stab_bad !== 0) begin
      errors++; $display("FAIL bp_stable: beats=%0d unstable=%0d required %0d/0", got.size(), stab_bad, exp.size());
    end
    tr_mode = 0; m_axis_tready = 1'b1;
  endtask

  task automatic test_forced_split();
    start();
    wr(32'h1100_0000 | $urandom_range(0, 32'hFFFF), 1'b0);
    for (int i = 0; i < 3; i++) wr($urandom, 1'b0);
    wr(32'h2200_0000 | $urandom_range(0, 32'hFFFF), 1'b0);
    wr($urandom, 1'b1);
    drain();
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL split_beat%0d: got %h required %h", i, (i < got.size()) ? got[i] : '0, exp[i]);
      end
    end
    checks++;
    if (got.size() !== 6 || got[3].l !== 1'b1 || got[3].t !== 8'h11 || got[4].t !== 8'h22 || got[4].u !== 4'd1 || pd_cnt !== 2) begin
      errors++;
      $display("FAIL split_framing: beats=%0d pkts=%0d required 6 beats, 2 packets", got.size(), pd_cnt);
    end
  endtask

  task automatic test_full();
    int n = 0;
    logic [31:0] w[DEPTH+1];
    start();
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    foreach (w[i]) w[i] = $urandom;
    fork
      for (int i = 0; i <= DEPTH; i++) wr(w[i], i == DEPTH);
    join_none
    while (fifo_level != DEPTH && n < 200) begin
      @(posedge clk); #1; n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fifo_level !== DEPTH || wr_ready !== 1'b0 || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL full_level: level=%0d wr_ready=%b tvalid=%b required %0d/0/1", fifo_level, wr_ready, m_axis_tvalid, DEPTH);
    end
    m_axis_tready = 1'b1;
    wait fork;
    drain();
    checks++;
    if (got.size() !== DEPTH + 1) begin errors++; $display("FAIL full_count: got %0d required %0d", got.size(), DEPTH + 1); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i] || got[i].d !== w[i]) begin
        errors++;
        $display("FAIL full_beat%0d: got %h required %h", i, (i < got.size()) ? got[i] : '0, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    start();
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 5; i++) wr(32'h3300_0000 + i, i == 5);
    m_axis_tready = 1'b1;
    while (got.size() < 2 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (got.size() !== 2 || m_axis_tvalid !== 1'b0 || fifo_level !== '0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop: beats=%0d tvalid=%b level=%0d wr_ready=%b required 2/0/0/0", got.size(), m_axis_tvalid, fifo_level, wr_ready);
    end
    exp.delete(); got.delete(); gcyc.delete();
    mpkt = 1'b0; pd_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    wr(32'h7E00_0000, 1'b1);
    drain();
    checks++;
    if (got.size() !== 1 || got[0] !== beat_t'{32'h7E00_0000, 1'b1, 4'd1, 8'h7E} || pd_cnt !== 1) begin
      errors++;
      $display("FAIL rstmid_after: beats=%0d first=%h pkts=%0d required 1 beat %h", got.size(),
               (got.size() > 0) ? got[0] : '0, pd_cnt, beat_t'{32'h7E00_0000, 1'b1, 4'd1, 8'h7E});
    end
  endtask

  task automatic test_stream();
    int cw;
    start();
    m_axis_tready = 1'b1;
    wr($urandom, 1'b0);
    cw = cyc;
    for (int i = 1; i < 64; i++) wr($urandom, ($urandom_range(0, 3) == 0) || i == 63);
    drain();
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL stream_beat%0d: got %h required %h", i, (i < got.size()) ? got[i] : '0, exp[i]);
      end
    end
    checks++;
    if (got.size() !== 64 || gcyc[0] !== cw + 2 || gcyc[63] - gcyc[0] !== 63) begin
      errors++;
      $display("FAIL stream_rate: beats=%0d first_delay=%0d span=%0d required 64/2/63", got.size(),
               (got.size() > 0) ? gcyc[0] - cw : -1, (got.size() == 64) ? gcyc[63] - gcyc[0] : -1);
    end
  endtask

  task automatic test_random();
    start();
    tr_mode = 1;
    for (int i = 0; i < 40; i++) wr($urandom, ($urandom_range(0, 3) == 0) || i == 39);
    drain();
    tr_mode = 0; m_axis_tready = 1'b1;
    drain();
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL random_beat%0d: got %h required %h", i, (i < got.size()) ? got[i] : '0, exp[i]);
      end
    end
    checks++;
    if (got.size() !== exp.size() || stab_bad !== 0 || pd_bad !== 0 || pd_cnt !== mpkts) begin
      errors++;
      $display("FAIL random_protocol: beats=%0d unstable=%0d misaligned=%0d pkts=%0d required %0d/0/0/%0d",
               got.size(), stab_bad, pd_bad, pd_cnt, exp.size(), mpkts);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_three_word();
    test_backpressure();
    test_forced_split();
    test_full();
    test_reset_mid();
    test_stream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
